ds_upsizer: RTL



---
 rtl/ds_upsizer.sv | 94 +++++++++
 1 files changed

// File: rtl/ds_upsizer.sv
// Width upsizer: packs RATIO consecutive IWIDTH-bit input words into one registered
// wide output word. Feeds the dual-clock FIFO so it is written once per group.
module ds_upsizer #(
   parameter int unsigned IWIDTH = 8,
   parameter int unsigned RATIO  = 4,
   parameter string       ORDER  = "LSB_FIRST"
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [IWIDTH-1:0]          i_dat,
   input  logic                       i_val,
   output logic                       i_rdy,
   output logic [IWIDTH*RATIO-1:0]    o_dat,
   output logic                       o_val,
   input  logic                       o_rdy
);

   localparam int unsigned CW        = ($clog2(RATIO) > 1) ? $clog2(RATIO) : 1;
   localparam int unsigned OW        = IWIDTH * RATIO;
   localparam int unsigned AW        = IWIDTH * (RATIO - 1);
   localparam bit          MSB_FIRST = (ORDER == "MSB_FIRST");
   localparam logic [CW-1:0] LAST    = CW'(RATIO - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [OW-1:0] o_dat_q, o_dat_d;
   logic          o_val_q, o_val_d;
   logic [OW-1:0] packed_c;
   logic          last_c;
   logic          in_xfer_c;
   logic          out_xfer_c;

   // Only the completing word stalls, and only while the output cannot drain.
   assign last_c     = (cnt_q == LAST);
   assign i_rdy      = ~(last_c & o_val_q & ~o_rdy);
   assign in_xfer_c  = i_val & i_rdy;
   assign out_xfer_c = o_val_q & o_rdy;

   assign o_dat = o_dat_q;
   assign o_val = o_val_q;

   // acc always holds word k in logical slot k; ORDER only affects the final merge.
   always_comb begin
      packed_c = '0;
      for (int unsigned k = 0; k < RATIO - 1; k++) begin
         if (MSB_FIRST)
            packed_c[(RATIO-1-k)*IWIDTH +: IWIDTH] = acc_q[k*IWIDTH +: IWIDTH];
         else
            packed_c[k*IWIDTH +: IWIDTH] = acc_q[k*IWIDTH +: IWIDTH];
      end
      if (MSB_FIRST)
         packed_c[IWIDTH-1:0] = i_dat;
      else
         packed_c[OW-1 -: IWIDTH] = i_dat;
   end

   // Next-state: a completing input overrides the drain so o_val stays high without a bubble.
   always_comb begin
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      o_dat_d = o_dat_q;
      o_val_d = o_val_q;
      if (out_xfer_c)
         o_val_d = 1'b0;
      if (in_xfer_c) begin
         if (last_c) begin
            o_dat_d = packed_c;
            o_val_d = 1'b1;
            cnt_d   = '0;
         end else begin
            for (int unsigned k = 0; k < RATIO - 1; k++) begin
               if (cnt_q == CW'(k))
                  acc_d[k*IWIDTH +: IWIDTH] = i_dat;
            end
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         acc_q   <= '0;
         o_dat_q <= '0;
         o_val_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         o_dat_q <= o_dat_d;
         o_val_q <= o_val_d;
      end
   end

endmodule
